// File: rtl/add_share_if.sv
// Request, shared-adder and response signals of add_share_arbiter, grouped with
// an arbiter-side (slave) and an environment-side (master) view.
interface add_share_if #(
    parameter int NREQ = 4,
    parameter int W    = 8
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_op1;
    logic [NREQ*W-1:0] req_op2;
    logic [W-1:0]      dp_op1;
    logic [W-1:0]      dp_op2;
    logic [W-1:0]      dp_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_result;
    logic [15:0]       done_cnt;

    modport slave (
        input  req_valid, req_op1, req_op2, dp_result, rsp_ready,
        output req_ready, dp_op1, dp_op2, rsp_valid, rsp_id, rsp_result, done_cnt
    );

    modport master (
        output req_valid, req_op1, req_op2, dp_result, rsp_ready,
        input  req_ready, dp_op1, dp_op2, rsp_valid, rsp_id, rsp_result, done_cnt
    );
endinterface

// File: rtl/add_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational adder between NREQ
// requesters and returns each sum tagged with its owner's ID.
module add_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    add_share_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [W-1:0]   op1_q, op1_d;
    logic [W-1:0]   op2_q, op2_d;
    logic [W-1:0]   rsp_result_q, rsp_result_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [15:0]    done_cnt_q, done_cnt_d;

    logic           any_vld;
    logic [IDW-1:0] win;
    logic [W-1:0]   win_op1, win_op2;
    logic           arb_en;

    // Scan downward from rr+NREQ-1 to rr so the closest set bit after rr wins last.
    always_comb begin
        int             idx;
        logic [IDW-1:0] idx_b;
        idx     = 0;
        idx_b   = '0;
        any_vld = 1'b0;
        win     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_b = IDW'(idx);
            if (bus.req_valid[idx_b]) begin
                any_vld = 1'b1;
                win     = idx_b;
            end
        end
    end

    always_comb begin
        win_op1 = '0;
        win_op2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                win_op1 = bus.req_op1[i*W +: W];
                win_op2 = bus.req_op2[i*W +: W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        id_d          = id_q;
        op1_d         = op1_q;
        op2_d         = op2_q;
        rsp_id_d      = rsp_id_q;
        rsp_result_d  = rsp_result_q;
        rsp_valid_d   = rsp_valid_q;
        done_cnt_d    = done_cnt_q;
        arb_en        = 1'b0;
        bus.req_ready = '0;
        bus.dp_op1    = '0;
        bus.dp_op2    = '0;

        case (state_q)
            IDLE: arb_en = 1'b1;
            EXEC: begin
                bus.dp_op1   = op1_q;
                bus.dp_op2   = op2_q;
                rsp_result_d = bus.dp_result;
                rsp_id_d     = id_q;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    done_cnt_d  = done_cnt_q + 16'd1;
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                    arb_en      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // rst_n gate keeps the grant low while reset is held with requests pending.
        if (arb_en && any_vld && rst_n) begin
            bus.req_ready[win] = 1'b1;
            op1_d   = win_op1;
            op2_d   = win_op2;
            id_d    = win;
            rr_d    = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
            state_d = EXEC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            id_q         <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_valid_q  <= 1'b0;
            done_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            id_q         <= id_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_valid_q  <= rsp_valid_d;
            done_cnt_q   <= done_cnt_d;
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.done_cnt   = done_cnt_q;
endmodule
